// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs variable-length LSB-first Huffman codes into fixed-width words,
// with ready/valid output backpressure and an end-of-block flush emitting a zero-padded last word.
module huffman_bit_packer #(
    parameter int OUT_WIDTH = 32,
    parameter int ACC_WIDTH = OUT_WIDTH + 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [63:0]                code_data,
    input  logic [7:0]                 code_bits,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic [$clog2(OUT_WIDTH):0] out_bits,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       flush_done,
    output logic [$clog2(ACC_WIDTH):0] fill_level
);
    localparam int FW = $clog2(ACC_WIDTH) + 1;
    localparam int BW = $clog2(OUT_WIDTH) + 1;
    localparam logic [FW-1:0] OUT_F = FW'(OUT_WIDTH);
    localparam logic [1:0] S_RUN = 2'd0, S_FLUSH = 2'd1, S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [FW-1:0]        r_fill;
    logic [OUT_WIDTH-1:0] r_data;
    logic [BW-1:0]        r_bits;
    logic                 r_valid;
    logic                 r_last;

    logic [6:0]           w_nbits;
    logic [63:0]          w_code;
    logic                 w_accept;
    logic                 w_slot_free;
    logic [ACC_WIDTH-1:0] w_acc;
    logic [FW-1:0]        w_fill;
    logic                 w_drain;
    logic                 w_last;

    assign w_nbits     = (code_bits > 8'd64) ? 7'd64 : code_bits[6:0];
    assign w_code      = code_data & ~({64{1'b1}} << w_nbits);
    assign in_ready    = reset_n && (r_state == S_RUN) && (r_fill <= OUT_F);
    assign w_accept    = in_ready && (code_bits != 8'd0);
    assign w_slot_free = !r_valid || out_ready;
    // Merging before draining lets a word completed this cycle leave on the same edge.
    assign w_acc       = r_acc | (w_accept ? (ACC_WIDTH'(w_code) << r_fill) : '0);
    assign w_fill      = r_fill + (w_accept ? FW'(w_nbits) : '0);
    assign w_drain     = w_slot_free && ((r_state == S_RUN) ? (w_fill >= OUT_F)
                                                            : (r_state == S_FLUSH) && (w_fill > OUT_F));
    assign w_last      = w_slot_free && (r_state == S_FLUSH) && (w_fill != '0) && (w_fill <= OUT_F);

    assign out_data    = r_data;
    assign out_bits    = r_bits;
    assign out_valid   = r_valid;
    assign out_last    = r_last;
    assign flush_done  = (r_state == S_DONE) && w_slot_free;
    assign fill_level  = r_fill;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
            r_acc   <= '0;
            r_fill  <= '0;
            r_data  <= '0;
            r_bits  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_acc  <= w_last ? '0 : w_drain ? (w_acc >> OUT_WIDTH) : w_acc;
            r_fill <= w_last ? '0 : w_drain ? (w_fill - OUT_F) : w_fill;
            if (w_drain || w_last) begin
                r_data  <= w_acc[OUT_WIDTH-1:0];
                r_bits  <= w_last ? BW'(w_fill) : BW'(OUT_WIDTH);
                r_last  <= w_last;
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            r_state <= (r_state == S_RUN)   ? (flush ? S_FLUSH : S_RUN) :
                       (r_state == S_FLUSH) ? ((w_last || w_fill == '0) ? S_DONE : S_FLUSH) :
                       (w_slot_free ? S_RUN : S_DONE);
        end
    end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer: scoreboard bench; a bit-queue model predicts every packed word.
module tb_huffman_bit_packer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [63:0] code_data = '0;
    logic [7:0]  code_bits = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic [5:0]  out_bits;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        flush_done;
    logic [7:0]  fill_level;

    typedef struct {
        logic [31:0] d;
        int          b;
        logic        l;
    } ent_t;

    ent_t sb[$];
    logic pend[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rnd = 1'b0;

    huffman_bit_packer #(.OUT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .code_data(code_data), .code_bits(code_bits),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_bits(out_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .flush_done(flush_done), .fill_level(fill_level)
    );

    always #5 clock = ~clock;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void emit_word(input int nb, input logic last);
        logic [31:0] w = '0;
        for (int i = 0; i < nb; i++) w[i] = pend.pop_front();
        sb.push_back('{w, nb, last});
    endfunction

    function automatic void push_code(input logic [63:0] d, input int n);
        int nb = (n > 64) ? 64 : n;
        for (int i = 0; i < nb; i++) pend.push_back(d[i]);
        while (pend.size() >= 32) emit_word(32, 1'b0);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the code has been accepted.
    task automatic send(input logic [63:0] d, input int n, input bit mdl);
        code_data = d;
        code_bits = 8'(n);
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (in_ready) break;
            @(posedge clock);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        expect_eq("in_ready_wait", in_ready, 1);
        @(posedge clock);
        if (mdl) push_code(d, n);
        #1;
        code_bits = 8'd0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_flush(input logic [63:0] d, input int n);
        code_data = d;
        code_bits = 8'(n);
        flush = 1'b1;
        @(posedge clock);
        if (n != 0) push_code(d, n);
        if (pend.size() != 0) emit_word(pend.size(), 1'b1);
        #1;
        flush = 1'b0;
        code_bits = 8'd0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            c++;
            expect_eq("flush_in_ready", in_ready, 0);
            if (flush_done) break;
        end
        expect_eq("flush_done", flush_done, 1);
        @(negedge clock);
        expect_eq("flush_done_pulse", flush_done, 0);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                expect_eq("spurious_word", out_valid, 0);
            end else begin
                expect_eq("word_data", out_data, sb[0].d);
                expect_eq("word_bits", out_bits, sb[0].b);
                expect_eq("word_last", out_last, sb[0].l);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic [63:0] d;
        #2 reset_n = 1'b0;
        #4;
        expect_eq("rst_out_valid", out_valid, 0);
        expect_eq("rst_out_data", out_data, 0);
        expect_eq("rst_out_bits", out_bits, 0);
        expect_eq("rst_out_last", out_last, 0);
        expect_eq("rst_flush_done", flush_done, 0);
        expect_eq("rst_fill", fill_level, 0);
        expect_eq("rst_in_ready", in_ready, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Four codes totalling exactly one word; word must appear the cycle after the last code.
        send(64'h0C, 8, 1);
        send(64'h1F3, 9, 1);
        send(64'h5, 3, 1);
        send(64'hABC, 12, 1);
        @(negedge clock);
        expect_eq("pack_valid", out_valid, 1);
        expect_eq("pack_data", out_data, 32'hABCBF30C);
        expect_eq("pack_bits", out_bits, 32);
        expect_eq("pack_fill", fill_level, 0);
        @(posedge clock);
        #1;

        // Partial flush, empty flush, flush with a same-cycle code.
        send(64'h7, 3, 1);
        do_flush(64'h0, 0);
        wait_done(c);
        expect_eq("flush_partial_cycles", c, 2);
        do_flush(64'h0, 0);
        wait_done(c);
        expect_eq("flush_empty_cycles", c, 2);
        do_flush(64'h15, 5);
        wait_done(c);
        expect_eq("flush_code_cycles", c, 2);

        // Masking of upper bits and clamping of oversized code_bits.
        send({64{1'b1}}, 5, 1);
        send({64{1'b1}}, 8'hFF, 1);
        do_flush(64'h0, 0);
        wait_done(c);
        expect_eq("flush_mask_cycles", c, 2);

        // Backpressure: slot stalls, accumulator fills, in_ready drops.
        out_ready = 1'b0;
        send({$urandom, $urandom}, 64, 1);
        send({$urandom, $urandom}, 64, 1);
        @(negedge clock);
        expect_eq("bp_in_ready", in_ready, 0);
        expect_eq("bp_fill", fill_level, 96);
        repeat (3) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            expect_eq("bp_hold_in_ready", in_ready, 0);
        end
        @(posedge clock);
        #1;
        rnd = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) send({$urandom, $urandom}, $urandom_range(0, 70), 1);
        rnd = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        do_flush(64'h0, 0);
        wait_done(c);
        expect_eq("bp_drained", sb.size(), 0);

        // Flush entered with exactly one word left in the accumulator.
        out_ready = 1'b0;
        d = {$urandom, $urandom};
        send(d, 64, 0);
        sb.push_back('{d[31:0], 32, 1'b0});
        sb.push_back('{d[63:32], 32, 1'b1});
        do_flush(64'h0, 0);
        repeat (3) begin
            @(negedge clock);
            expect_eq("exact_fill", fill_level, 32);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        wait_done(c);

        // Asynchronous reset while flushing with a stalled word.
        out_ready = 1'b0;
        d = {$urandom, $urandom};
        send(d, 64, 0);
        sb.push_back('{d[31:0], 32, 1'b0});
        send(64'h3FF, 10, 0);
        do_flush(64'h0, 0);
        #2;
        reset_n = 1'b0;
        sb.delete();
        pend.delete();
        #1;
        expect_eq("mid_rst_valid", out_valid, 0);
        expect_eq("mid_rst_data", out_data, 0);
        expect_eq("mid_rst_bits", out_bits, 0);
        expect_eq("mid_rst_last", out_last, 0);
        expect_eq("mid_rst_fill", fill_level, 0);
        expect_eq("mid_rst_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(64'h3, 2, 1);
        do_flush(64'h0, 0);
        wait_done(c);
        expect_eq("post_rst_cycles", c, 2);

        repeat (3) @(posedge clock);
        expect_eq("sb_drained", sb.size(), 0);
        expect_eq("model_drained", pend.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
